// File: rtl/valid_ready_packer_if.sv
// Stream bundle around the packer: narrow beats in, wide words out.
// No latency of its own; it only carries signals.
// ready_up / ready_down carry the backpressure in each direction.
interface valid_ready_packer_if #(
  parameter int width = 4,
  parameter int ratio = 4
);
  // Narrow upstream side
  logic [width-1:0]       data_up;
  logic                   valid_up;
  logic                   last_up;
  logic                   ready_up;

  // Wide downstream side
  logic                   valid_down;
  logic [width*ratio-1:0] data_down;
  logic [ratio-1:0]       keep_down;
  logic                   last_down;
  logic                   ready_down;

  // Traffic side: it sources narrow beats and sinks wide words.
  modport master (
    output data_up, valid_up, last_up, ready_down,
    input  ready_up, valid_down, data_down, keep_down, last_down
  );

  // Packer side.
  modport slave (
    input  data_up, valid_up, last_up, ready_down,
    output ready_up, valid_down, data_down, keep_down, last_down
  );
endinterface

// File: rtl/valid_ready_packer.sv
// Packs ratio narrow beats into one wide word; last_up flushes a partial word with keep bits.
// Latency: 1 cycle from the completing beat to valid_down.
// Backpressure: a held word with ready_down low drops ready_up in the same cycle, with no skid.
module valid_ready_packer #(
  parameter int width = 4,
  parameter int ratio = 4
) (
  input logic                 clk,
  input logic                 rst,
  valid_ready_packer_if.slave bus
);

  localparam int CW = $clog2(ratio);
  localparam int DW = width * ratio;
  localparam logic [CW-1:0] LAST_LANE = CW'(ratio - 1);

  // Lane accumulator
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    acc_dat_q, acc_dat_d;
  logic [ratio-1:0] acc_keep_q, acc_keep_d;

  // Output register
  logic             valid_q, valid_d;
  logic [DW-1:0]    dat_q, dat_d;
  logic [ratio-1:0] keep_q, keep_d;
  logic             last_q, last_d;

  // Handshake terms
  logic             ready_up;
  logic             acc;
  logic             complete;

  // Accumulator contents with the current beat merged in
  logic [DW-1:0]    img_dat;
  logic [ratio-1:0] img_keep;

  // ready_up depends only on registered state, ready_down and reset.
  // It never depends on valid_up, so it cannot form a combinational loop upstream.
  assign ready_up = rst && (!valid_q || bus.ready_down);
  assign acc      = bus.valid_up && ready_up;
  assign complete = acc && ((cnt_q == LAST_LANE) || bus.last_up);

  // Merge the incoming beat into lane cnt of the current accumulator contents.
  always_comb begin
    img_dat  = acc_dat_q;
    img_keep = acc_keep_q;
    for (int i = 0; i < ratio; i++) begin
      if (cnt_q == CW'(i)) begin
        img_dat[i*width +: width] = bus.data_up;
        img_keep[i]               = 1'b1;
      end
    end
  end

  // Accumulator next state: advance on a partial beat, empty on completion.
  always_comb begin
    cnt_d      = cnt_q;
    acc_dat_d  = acc_dat_q;
    acc_keep_d = acc_keep_q;
    if (complete) begin
      cnt_d      = '0;
      acc_dat_d  = '0;
      acc_keep_d = '0;
    end else if (acc) begin
      cnt_d      = cnt_q + CW'(1);
      acc_dat_d  = img_dat;
      acc_keep_d = img_keep;
    end
  end

  // Output next state: a completion loads a new word, even while the old
  // one drains, so words can go out back to back. A drain with no
  // completion only drops valid. Data, keep and last keep their values.
  always_comb begin
    valid_d = valid_q;
    dat_d   = dat_q;
    keep_d  = keep_q;
    last_d  = last_q;
    if (complete) begin
      valid_d = 1'b1;
      dat_d   = img_dat;
      keep_d  = img_keep;
      last_d  = bus.last_up;
    end else if (valid_q && bus.ready_down) begin
      valid_d = 1'b0;
    end
  end

  // State registers. Reset discards any partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      acc_dat_q  <= '0;
      acc_keep_q <= '0;
      valid_q    <= 1'b0;
      dat_q      <= '0;
      keep_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_dat_q  <= acc_dat_d;
      acc_keep_q <= acc_keep_d;
      valid_q    <= valid_d;
      dat_q      <= dat_d;
      keep_q     <= keep_d;
      last_q     <= last_d;
    end
  end

  assign bus.ready_up   = ready_up;
  assign bus.valid_down = valid_q;
  assign bus.data_down  = dat_q;
  assign bus.keep_down  = keep_q;
  assign bus.last_down  = last_q;

endmodule

// File: tb/tb_valid_ready_packer.sv
// Directed bench for valid_ready_packer with width=4 and ratio=4.
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.
// Expected words are hand-computed constants.
module tb_valid_ready_packer;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  valid_ready_packer_if #(.width(4), .ratio(4)) bus ();

  valid_ready_packer #(.width(4), .ratio(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one beat at the falling edge; the next rising edge takes it.
  task automatic beat(input logic [3:0] d, input logic l);
    @(negedge clk);
    bus.valid_up = 1'b1;
    bus.data_up  = d;
    bus.last_up  = l;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.valid_up = 1'b0;
    bus.last_up  = 1'b0;
  endtask

  logic [3:0]  vals3  [12];
  logic [15:0] words3 [3];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst            = 1'b0;
    bus.valid_up   = 1'b0;
    bus.data_up    = '0;
    bus.last_up    = 1'b0;
    bus.ready_down = 1'b1;
    vals3  = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    words3 = '{16'hDCBA, 16'h10FE, 16'h5432};

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(bus.valid_down), 32'h0);
    check("rst_data",  32'(bus.data_down),  32'h0);
    check("rst_keep",  32'(bus.keep_down),  32'h0);
    check("rst_last",  32'(bus.last_down),  32'h0);
    check("rst_ready", 32'(bus.ready_up),   32'h0);
    rst = 1'b1;
    #1;
    check("rel_ready", 32'(bus.ready_up), 32'h1);

    // Full word 1,2,3,4
    beat(4'h1, 1'b0);
    beat(4'h2, 1'b0);
    beat(4'h3, 1'b0);
    beat(4'h4, 1'b0);
    idle();
    check("w1_valid", 32'(bus.valid_down), 32'h1);
    check("w1_data",  32'(bus.data_down),  32'h4321);
    check("w1_keep",  32'(bus.keep_down),  32'hF);
    check("w1_last",  32'(bus.last_down),  32'h0);
    idle();
    check("w1_valid_drop", 32'(bus.valid_down), 32'h0);

    // Flushed partial word 5,6
    beat(4'h5, 1'b0);
    beat(4'h6, 1'b1);
    idle();
    check("w2_valid", 32'(bus.valid_down), 32'h1);
    check("w2_data",  32'(bus.data_down),  32'h0065);
    check("w2_keep",  32'(bus.keep_down),  32'h3);
    check("w2_last",  32'(bus.last_down),  32'h1);

    // Twelve continuous beats produce three words, four cycles apart
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("st_valid", 32'(bus.valid_down), (i % 4 == 0) ? 32'h1 : 32'h0);
        if (i % 4 == 0) begin
          check("st_data", 32'(bus.data_down), 32'(words3[i/4 - 1]));
          check("st_keep", 32'(bus.keep_down), 32'hF);
        end
      end
      if (i < 12) begin
        check("st_ready", 32'(bus.ready_up), 32'h1);
        bus.valid_up = 1'b1;
        bus.data_up  = vals3[i];
        bus.last_up  = 1'b0;
      end else begin
        bus.valid_up = 1'b0;
      end
    end

    // Backpressure: hold a word for 5 cycles while a beat waits upstream
    @(negedge clk);
    bus.ready_down = 1'b0;
    bus.valid_up   = 1'b1;
    bus.data_up    = 4'h8;
    bus.last_up    = 1'b0;
    beat(4'h9, 1'b0);
    beat(4'hA, 1'b0);
    beat(4'hB, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus.valid_up = 1'b1;
        bus.data_up  = 4'h7;
        bus.last_up  = 1'b1;
      end
      check("bp_ready", 32'(bus.ready_up),   32'h0);
      check("bp_valid", 32'(bus.valid_down), 32'h1);
      check("bp_data",  32'(bus.data_down),  32'hBA98);
    end
    @(negedge clk);
    bus.ready_down = 1'b1;
    #1;
    check("bp_ready_rise", 32'(bus.ready_up), 32'h1);
    idle();
    check("bp_next_valid", 32'(bus.valid_down), 32'h1);
    check("bp_next_data",  32'(bus.data_down),  32'h0007);
    check("bp_next_keep",  32'(bus.keep_down),  32'h1);
    check("bp_next_last",  32'(bus.last_down),  32'h1);
    idle();
    check("bp_drained", 32'(bus.valid_down), 32'h0);

    // last_up on every beat: one single-lane word per cycle
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("l1_valid", 32'(bus.valid_down), 32'h1);
        check("l1_keep",  32'(bus.keep_down),  32'h1);
        check("l1_data",  32'(bus.data_down),  32'(i + 2));
        check("l1_last",  32'(bus.last_down),  32'h1);
      end
      if (i < 6) begin
        bus.valid_up = 1'b1;
        bus.data_up  = 4'(i + 3);
        bus.last_up  = 1'b1;
      end else begin
        bus.valid_up = 1'b0;
        bus.last_up  = 1'b0;
      end
    end

    // Reset in the middle of a word
    beat(4'h1, 1'b0);
    beat(4'h2, 1'b0);
    beat(4'h3, 1'b0);
    idle();
    #2;
    rst = 1'b0;
    #1;
    check("mr_valid", 32'(bus.valid_down), 32'h0);
    check("mr_data",  32'(bus.data_down),  32'h0);
    check("mr_keep",  32'(bus.keep_down),  32'h0);
    check("mr_last",  32'(bus.last_down),  32'h0);
    check("mr_ready", 32'(bus.ready_up),   32'h0);
    @(negedge clk);
    rst = 1'b1;
    beat(4'hC, 1'b0);
    beat(4'hD, 1'b0);
    beat(4'hE, 1'b0);
    beat(4'hF, 1'b0);
    idle();
    check("mr_word_valid", 32'(bus.valid_down), 32'h1);
    check("mr_word_data",  32'(bus.data_down),  32'hFEDC);
    check("mr_word_keep",  32'(bus.keep_down),  32'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
